// File: rtl/spi_link_pkg.sv
// Shared SPI link definitions for the ciphertext transmit and receive sides.
// Both ends use these constants so they agree on the frame size and the
// block count.
package spi_link_pkg;

  localparam int SPI_DATA_WIDTH  = 32;
  localparam int CIPHERTEXT_BITS = 4096;
  localparam int SPI_NUM_BLOCKS  = CIPHERTEXT_BITS / SPI_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_rx_state_t;

endpackage

// File: rtl/pipeliner.sv
// Generic flop pipeline. Here it is used as a multi-bit input synchronizer.
// Ports:
//   clk_in   - clock
//   rst_in   - synchronous active-high reset; every stage loads RESET_VALUE
//   data_in  - DATA_BIT_SIZE-wide input
//   data_out - data_in delayed by PIPELINE_STAGE_COUNT cycles
module pipeliner #(
  parameter int                         DATA_BIT_SIZE        = 1,
  parameter int                         PIPELINE_STAGE_COUNT = 2,
  parameter logic [DATA_BIT_SIZE-1:0]   RESET_VALUE          = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [DATA_BIT_SIZE-1:0] data_in,
  output logic [DATA_BIT_SIZE-1:0] data_out
);

  logic [PIPELINE_STAGE_COUNT-1:0][DATA_BIT_SIZE-1:0] stages;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < PIPELINE_STAGE_COUNT; i++) stages[i] <= RESET_VALUE;
    end else begin
      stages[0] <= data_in;
      for (int i = 1; i < PIPELINE_STAGE_COUNT; i++) stages[i] <= stages[i-1];
    end
  end

  assign data_out = stages[PIPELINE_STAGE_COUNT-1];

endmodule

// File: rtl/spi_ciphertext_receiver.sv
// SPI mode-0 peripheral receiver for the ciphertext stream.
// Each chip-select frame carries one DATA_WIDTH-bit word, sent MSB first.
// Each complete word is emitted as a one-cycle valid pulse, together with its
// block index (0 = least-significant block) and a last-block flag.
// Ports:
//   clk_in, rst_in   - system clock, synchronous active-high reset
//   copi_in, dclk_in, cs_in - asynchronous SPI pins (cs active low, dclk idles low)
//   data_out         - last received word, held until the next one
//   data_valid_out   - one-cycle pulse when data_out is new
//   block_index_out  - block index of the word on data_out
//   last_block_out   - high with data_valid_out for the final block
//   frame_error_out  - one-cycle pulse on an aborted or overlong frame
module spi_ciphertext_receiver
  import spi_link_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int BITS_IN_NUM = CIPHERTEXT_BITS,
  parameter int SYNC_STAGES = 2,
  localparam int NUM_BLOCKS = BITS_IN_NUM / DATA_WIDTH,
  localparam int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  copi_in,
  input  logic                  dclk_in,
  input  logic                  cs_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic [IDX_W-1:0]      block_index_out,
  output logic                  last_block_out,
  output logic                  frame_error_out
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Sync chains reset to the bus idle level: cs high, dclk low, copi low.
  logic [2:0] sync_q;
  pipeliner #(
    .DATA_BIT_SIZE       (3),
    .PIPELINE_STAGE_COUNT(SYNC_STAGES),
    .RESET_VALUE         (3'b100)
  ) u_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .data_in ({cs_in, dclk_in, copi_in}),
    .data_out(sync_q)
  );

  logic cs_s, dclk_s, copi_s, dclk_d, dclk_rise;
  assign cs_s      = sync_q[2];
  assign dclk_s    = sync_q[1];
  assign copi_s    = sync_q[0];
  assign dclk_rise = dclk_s & ~dclk_d;

  spi_rx_state_t         state;
  // Only the lower DATA_WIDTH-1 bits are kept. The final bit is joined on
  // directly into data_out when the word completes.
  logic [DATA_WIDTH-2:0] word;
  logic [CNT_W-1:0]      bit_count;
  logic                  overrun;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      dclk_d          <= 1'b0;
      word            <= '0;
      bit_count       <= '0;
      overrun         <= 1'b0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      block_index_out <= '0;
      last_block_out  <= 1'b0;
      frame_error_out <= 1'b0;
    end else begin
      dclk_d          <= dclk_s;
      data_valid_out  <= 1'b0;
      last_block_out  <= 1'b0;
      frame_error_out <= 1'b0;

      // The index advances only after the pulse, so the consumer sees the
      // index of the word that is being presented.
      if (data_valid_out)
        block_index_out <= (block_index_out == LAST_IDX) ? '0 : block_index_out + IDX_W'(1);

      case (state)
        // State changes only send us back to IDLE once cs is high. A low cs
        // here therefore always marks a new frame, including the case of a
        // cs that is still low when reset is released.
        IDLE: begin
          if (!cs_s) begin
            word      <= '0;
            bit_count <= '0;
            overrun   <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // The final edge is checked first, so a word whose last edge
          // arrives in the same cycle as cs rising still completes.
          if (dclk_rise && bit_count == LAST_BIT) begin
            data_out       <= {word, copi_s};
            data_valid_out <= 1'b1;
            last_block_out <= (block_index_out == LAST_IDX);
            bit_count      <= bit_count + CNT_W'(1);
            state          <= cs_s ? IDLE : DONE;
          end else if (cs_s) begin
            frame_error_out <= (bit_count != '0);
            state           <= IDLE;
          end else if (dclk_rise) begin
            word      <= {word[DATA_WIDTH-3:0], copi_s};
            bit_count <= bit_count + CNT_W'(1);
          end
        end
        DONE: begin
          if (cs_s) begin
            frame_error_out <= overrun;
            state           <= IDLE;
          end else if (dclk_rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ciphertext_receiver.sv
module tb_spi_ciphertext_receiver;

  logic        clk_in = 1'b0;
  logic        rst_in, copi_in, dclk_in, cs_in;
  logic [31:0] data_out;
  logic        data_valid_out, last_block_out, frame_error_out;
  logic [6:0]  block_index_out;

  spi_ciphertext_receiver dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .copi_in        (copi_in),
    .dclk_in        (dclk_in),
    .cs_in          (cs_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .block_index_out(block_index_out),
    .last_block_out (last_block_out),
    .frame_error_out(frame_error_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int half     = 50;

  // Monitor: samples on the falling edge and logs every pulse.
  int          vcnt = 0;
  int          ecnt = 0;
  logic [31:0] got_data[$];
  logic [6:0]  got_idx[$];
  logic        got_last[$];

  always @(negedge clk_in) begin
    if (data_valid_out) begin
      vcnt++;
      got_data.push_back(data_out);
      got_idx.push_back(block_index_out);
      got_last.push_back(last_block_out);
    end
    if (frame_error_out) ecnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive_range(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      copi_in = w[i];
      cyc(half);
      dclk_in = 1'b1;
      cyc(half);
      dclk_in = 1'b0;
    end
  endtask

  task automatic start_frame();
    cs_in = 1'b0;
    cyc(half);
  endtask

  task automatic end_frame();
    cyc(half);
    cs_in = 1'b1;
    cyc(half + 10);
  endtask

  task automatic send_word(input logic [31:0] w);
    start_frame();
    drive_range(w, 31, 0);
    end_frame();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cyc(3);
    rst_in = 1'b0;
    cyc(5);
  endtask

  task automatic test_reset();
    cs_in = 1'b1; dclk_in = 1'b0; copi_in = 1'b0; rst_in = 1'b1;
    cyc(4);
    n_checks++; if (data_out !== 32'h0) $display("FAIL reset_data: got %h expected 0", data_out); else n_pass++;
    n_checks++; if (data_valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", data_valid_out); else n_pass++;
    n_checks++; if (block_index_out !== 7'd0) $display("FAIL reset_index: got %0d expected 0", block_index_out); else n_pass++;
    n_checks++; if (last_block_out !== 1'b0) $display("FAIL reset_last: got %b expected 0", last_block_out); else n_pass++;
    n_checks++; if (frame_error_out !== 1'b0) $display("FAIL reset_error: got %b expected 0", frame_error_out); else n_pass++;
    rst_in = 1'b0;
    cyc(5);
  endtask

  task automatic test_single();
    int v0, e0;
    half = 50; v0 = vcnt; e0 = ecnt;
    send_word(32'hDEADBEEF);
    n_checks++; if (vcnt - v0 !== 1) $display("FAIL single_count: got %0d expected 1", vcnt - v0); else n_pass++;
    if (vcnt - v0 >= 1) begin
      n_checks++; if (got_data[v0] !== 32'hDEADBEEF) $display("FAIL single_data: got %h expected deadbeef", got_data[v0]); else n_pass++;
      n_checks++; if (got_idx[v0] !== 7'd0) $display("FAIL single_index: got %0d expected 0", got_idx[v0]); else n_pass++;
      n_checks++; if (got_last[v0] !== 1'b0) $display("FAIL single_last: got %b expected 0", got_last[v0]); else n_pass++;
    end
    n_checks++; if (ecnt - e0 !== 0) $display("FAIL single_error: got %0d expected 0", ecnt - e0); else n_pass++;
    cyc(20);
    n_checks++; if (data_out !== 32'hDEADBEEF) $display("FAIL single_hold: got %h expected deadbeef", data_out); else n_pass++;
  endtask

  task automatic test_all_blocks();
    int v0;
    do_reset();
    half = 5;
    for (int k = 0; k < 129; k++) begin
      v0 = vcnt;
      send_word(32'(k));
      n_checks++;
      if (vcnt - v0 !== 1) $display("FAIL blk_count[%0d]: got %0d expected 1", k, vcnt - v0);
      else if (got_data[v0] !== 32'(k) || got_idx[v0] !== 7'(k % 128) || got_last[v0] !== (k == 127))
        $display("FAIL blk[%0d]: got data %h idx %0d last %b expected data %h idx %0d last %b",
                 k, got_data[v0], got_idx[v0], got_last[v0], 32'(k), k % 128, (k == 127));
      else n_pass++;
    end
    half = 50;
  endtask

  task automatic test_abort();
    int v0, e0;
    half = 50; v0 = vcnt; e0 = ecnt;
    start_frame();
    drive_range(32'hA5A5A5A5, 31, 15);
    end_frame();
    n_checks++; if (ecnt - e0 !== 1) $display("FAIL abort_error: got %0d expected 1", ecnt - e0); else n_pass++;
    n_checks++; if (vcnt - v0 !== 0) $display("FAIL abort_valid: got %0d expected 0", vcnt - v0); else n_pass++;
    v0 = vcnt;
    send_word(32'h12345678);
    n_checks++;
    if (vcnt - v0 !== 1) $display("FAIL abort_next_count: got %0d expected 1", vcnt - v0);
    else if (got_data[v0] !== 32'h12345678 || got_idx[v0] !== 7'd1)
      $display("FAIL abort_next: got data %h idx %0d expected data 12345678 idx 1", got_data[v0], got_idx[v0]);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int v0, e0;
    half = 50; v0 = vcnt; e0 = ecnt;
    start_frame();
    drive_range(32'hCAFEF00D, 31, 0);
    drive_range(32'h3, 1, 0);
    end_frame();
    n_checks++;
    if (vcnt - v0 !== 1) $display("FAIL overrun_count: got %0d expected 1", vcnt - v0);
    else if (got_data[v0] !== 32'hCAFEF00D || got_idx[v0] !== 7'd2)
      $display("FAIL overrun_word: got data %h idx %0d expected data cafef00d idx 2", got_data[v0], got_idx[v0]);
    else n_pass++;
    n_checks++; if (ecnt - e0 !== 1) $display("FAIL overrun_error: got %0d expected 1", ecnt - e0); else n_pass++;
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    cs_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      copi_in = i[0];
      dclk_in = 1'b1; cyc(8);
      dclk_in = 1'b0; cyc(8);
    end
    cs_in = 1'b0; cyc(30);
    cs_in = 1'b1; cyc(30);
    n_checks++; if (vcnt - v0 !== 0) $display("FAIL glitch_valid: got %0d expected 0", vcnt - v0); else n_pass++;
    n_checks++; if (ecnt - e0 !== 0) $display("FAIL glitch_error: got %0d expected 0", ecnt - e0); else n_pass++;
    n_checks++; if (block_index_out !== 7'd3) $display("FAIL glitch_index: got %0d expected 3", block_index_out); else n_pass++;
  endtask

  task automatic test_midframe_reset();
    int v0;
    half = 50;
    start_frame();
    drive_range(32'hFFFF0000, 31, 22);
    rst_in = 1'b1;
    cyc(1);
    rst_in = 1'b0;
    n_checks++;
    if (data_out !== 32'h0 || data_valid_out !== 1'b0 || block_index_out !== 7'd0 ||
        last_block_out !== 1'b0 || frame_error_out !== 1'b0)
      $display("FAIL midreset_outputs: got data %h v %b idx %0d last %b err %b expected all 0",
               data_out, data_valid_out, block_index_out, last_block_out, frame_error_out);
    else n_pass++;
    v0 = vcnt;
    drive_range(32'hFFFF0000, 21, 0);
    end_frame();
    n_checks++; if (vcnt - v0 !== 0) $display("FAIL midreset_rest: got %0d expected 0", vcnt - v0); else n_pass++;
    v0 = vcnt;
    send_word(32'h0000FFFF);
    n_checks++;
    if (vcnt - v0 !== 1) $display("FAIL midreset_next_count: got %0d expected 1", vcnt - v0);
    else if (got_data[v0] !== 32'h0000FFFF || got_idx[v0] !== 7'd0)
      $display("FAIL midreset_next: got data %h idx %0d expected data 0000ffff idx 0", got_data[v0], got_idx[v0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_blocks();
    test_abort();
    test_overrun();
    test_glitch();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
